// File: rtl/repeated_add_multiplier.sv
// repeated_add_multiplier: free-running unsigned multiplier built from one
// addition per clock. It watches its operand inputs, restarts whenever they
// change, and updates product only when a whole computation completes.
// Optional build macro RAM_MIN_ITER_EN: iterate over the smaller operand and
// add the larger one, which shortens latency to min(operands)+2 edges.
module repeated_add_multiplier #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH_IN-1:0]  multiplicand,
  input  logic [WIDTH_IN-1:0]  multiplier,
  output logic [WIDTH_OUT-1:0] product
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [WIDTH_IN-1:0]   op_a, op_a_next;
  logic [WIDTH_IN-1:0]   op_b, op_b_next;
  logic [WIDTH_IN-1:0]   cnt, cnt_next;
  logic [WIDTH_OUT-1:0]  acc, acc_next;
  logic [WIDTH_OUT-1:0]  product_next;
  logic [WIDTH_IN-1:0]   addend;
  logic [WIDTH_IN-1:0]   load_cnt;
  logic [WIDTH_IN-1:0]   load_addend;
  logic                  inputs_changed;

  // op_a/op_b always mirror the raw inputs so change detection stays simple;
  // the value actually added lives in addend, which may differ from op_a
  // when the minimum-iteration option swaps the roles of the operands.
`ifdef RAM_MIN_ITER_EN
  logic [WIDTH_IN-1:0] addend_reg, addend_reg_next;

  // Pick the smaller operand as the iteration count, the larger as addend.
  always_comb begin
    load_cnt    = multiplier;
    load_addend = multiplicand;
    if (multiplicand < multiplier) begin
      load_cnt    = multiplicand;
      load_addend = multiplier;
    end
  end

  assign addend = addend_reg;

  // Addend register, cleared on reset and reloaded on every capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addend_reg <= '0;
    end else begin
      addend_reg <= addend_reg_next;
    end
  end

  // Next addend follows the capture decision made by the main FSM.
  always_comb begin
    addend_reg_next = addend_reg;
    if (inputs_changed) begin
      addend_reg_next = load_addend;
    end
  end
`else
  assign load_cnt    = multiplier;
  assign load_addend = multiplicand;
  assign addend      = op_a;
`endif

  assign inputs_changed = ({multiplicand, multiplier} != {op_a, op_b});

  // State and datapath registers; reset parks the block in DONE with
  // zero operands, so 0x0 after reset needs no computation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= DONE;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      state   <= state_next;
      op_a    <= op_a_next;
      op_b    <= op_b_next;
      cnt     <= cnt_next;
      acc     <= acc_next;
      product <= product_next;
    end
  end

  // Next-state logic: an operand change wins in every state and restarts the
  // computation; otherwise ACCUM adds once per clock and publishes the sum
  // in a single step once the count reaches zero, so no partial sum leaks.
  always_comb begin
    state_next   = state;
    op_a_next    = op_a;
    op_b_next    = op_b;
    cnt_next     = cnt;
    acc_next     = acc;
    product_next = product;

    if (inputs_changed) begin
      op_a_next  = multiplicand;
      op_b_next  = multiplier;
      acc_next   = '0;
      cnt_next   = load_cnt;
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (cnt != '0) begin
            acc_next = acc + WIDTH_OUT'(addend);
            cnt_next = cnt - WIDTH_IN'(1);
          end else begin
            product_next = acc;
            state_next   = DONE;
          end
        end
        IDLE, DONE: begin
          state_next = state;
        end
        default: begin
          state_next = DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repeated_add_multiplier.sv
// Testbench for repeated_add_multiplier: table-driven vectors, hand-written
// abort and mid-operation reset sequences, and randomized operands checked
// against a plain-arithmetic reference model.
module tb_repeated_add_multiplier;

  logic        clk_tb;
  logic        rst_n_tb;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;

  int pass_count;
  int check_count;

  // Reference model state: last operands the block has seen and the product
  // it should currently be presenting.
  logic [7:0]  model_a;
  logic [7:0]  model_b;
  logic [15:0] model_product;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vector_t;

  vector_t vectors[8];

  repeated_add_multiplier #(
    .WIDTH_IN  (8),
    .WIDTH_OUT (16)
  ) dut (
    .CLK          (clk_tb),
    .RST_N        (rst_n_tb),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  // Edges from capture to a visible result, counting the capture edge as 1.
  function automatic int refLatency(input logic [7:0] a, input logic [7:0] b);
`ifdef RAM_MIN_ITER_EN
    return ((a < b) ? int'(a) : int'(b)) + 2;
`else
    return int'(b) + 2;
`endif
  endfunction

  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
    int full;
    full = int'(a) * int'(b);
    return full[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: product=%0d expected=%0d at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Step through the latency window: product must hold its previous value
  // on every edge before the last, then show the new result.
  task automatic waitResult(input int lat, input logic [15:0] expected,
                            input string tag);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk_tb);
      #1;
      if (k < lat) checkOutput({tag, " hold"}, product, model_product);
      else         checkOutput({tag, " result"}, product, expected);
    end
    model_product = expected;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expected, input string tag);
    @(negedge clk_tb);
    multiplicand = a;
    multiplier   = b;
    model_a      = a;
    model_b      = b;
    waitResult(refLatency(a, b), expected, tag);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    pass_count    = 0;
    check_count   = 0;
    model_a       = '0;
    model_b       = '0;
    model_product = '0;

    vectors[0] = '{a: 8'd7,   b: 8'd5,   expected: 16'd35};
    vectors[1] = '{a: 8'd255, b: 8'd255, expected: 16'd65025};
    vectors[2] = '{a: 8'd0,   b: 8'd255, expected: 16'd0};
    vectors[3] = '{a: 8'd1,   b: 8'd1,   expected: 16'd1};
    vectors[4] = '{a: 8'd16,  b: 8'd16,  expected: 16'd256};
    vectors[5] = '{a: 8'd200, b: 8'd0,   expected: 16'd0};
    vectors[6] = '{a: 8'd12,  b: 8'd34,  expected: 16'd408};
    vectors[7] = '{a: 8'd255, b: 8'd1,   expected: 16'd255};

    // Reset held for 10 cycles with zero operands.
    rst_n_tb     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("reset held", product, 16'd0);
    end
    @(negedge clk_tb);
    rst_n_tb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("idle after reset", product, 16'd0);
    end

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expected,
                    $sformatf("vector%0d", i));
    end

    // Result must stay stable while operands are unchanged.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("stable after done", product, model_product);
    end

    $display("[TB] abort during accumulation");
    @(negedge clk_tb);
    multiplicand = 8'd3;
    multiplier   = 8'd200;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("abort pre hold", product, model_product);
    end
    applyStimulus(8'd4, 8'd2, 16'd8, "abort restart");
    for (int i = 0; i < 220; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("no stale 600", product, 16'd8);
    end

    $display("[TB] reset during accumulation");
    @(negedge clk_tb);
    multiplicand = 8'd9;
    multiplier   = 8'd100;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_tb);
      #1;
      checkOutput("pre reset hold", product, model_product);
    end
    #2;
    rst_n_tb = 1'b0;
    #1;
    checkOutput("async reset", product, 16'd0);
    model_product = '0;
    model_a       = '0;
    model_b       = '0;
    @(negedge clk_tb);
    @(negedge clk_tb);
    checkOutput("reset still held", product, 16'd0);
    rst_n_tb = 1'b1;
    model_a  = 8'd9;
    model_b  = 8'd100;
    waitResult(refLatency(8'd9, 8'd100), 16'd900, "post reset");

    $display("[TB] randomized operands");
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i < 6) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 60));
      if (ra == model_a && rb == model_b) rb = rb + 8'd1;
      applyStimulus(ra, rb, refProduct(ra, rb), $sformatf("random%0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
